sisc_fetch: RTL



---
 rtl/sisc_pkg.sv | 30 +++
 rtl/sisc_pc_next.sv | 24 ++
 rtl/sisc_fetch.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch stage: widths, opcode field, FSM states
// and next-PC select codes.
package sisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int OP_W    = OP_MSB - OP_LSB + 1;

  localparam logic [OP_W-1:0] HALT_OP_DEF = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_REL  = 2'd2,
    PC_ABS  = 2'd3
  } pc_sel_e;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC select: hold, increment, relative add or absolute load,
// all with 16-bit wrap (carry dropped).
module sisc_pc_next
  import sisc_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] imm_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  // Select the next program counter value.
  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      PC_HOLD: pc_next_o = pc_i;
      PC_INC:  pc_next_o = pc_i + 16'd1;
      PC_REL:  pc_next_o = pc_i + imm_i;
      PC_ABS:  pc_next_o = imm_i;
      default: pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch stage: owns the PC, captures instructions into ir and
// hands them to decode over valid/ready, applying taken branches and HALT.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [OP_W-1:0]   HALT_OP  = HALT_OP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic               br_abs,
  input  logic [ADDR_W-1:0]  br_imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  pc_sel_e            pc_sel_s;
  logic               is_halt_s;
  logic               accept_s;

  assign is_halt_s = (opcode_of(im_data) == HALT_OP);
  assign accept_s  = ir_valid_q & ir_ready;

  sisc_pc_next u_pc_next (
    .pc_i      (pc_q),
    .sel_i     (pc_sel_s),
    .imm_i     (br_imm),
    .pc_next_o (pc_d)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic; HALT is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (is_halt_s) begin
          state_d = HALT;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept_s) begin
          state_d = FETCH;
        end else begin
          state_d = ISSUE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Per-state datapath controls; branch inputs are only looked at on acceptance in ISSUE.
  always_comb begin
    pc_sel_s   = PC_HOLD;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      FETCH: begin
        ir_d       = im_data;
        ir_valid_d = 1'b1;
        pc_sel_s   = PC_INC;
        halted_d   = is_halt_s;
      end
      ISSUE: begin
        if (accept_s) begin
          ir_valid_d = 1'b0;
          if (br_taken) begin
            pc_sel_s = br_abs ? PC_ABS : PC_REL;
          end else begin
            pc_sel_s = PC_HOLD;
          end
        end else begin
          pc_sel_s = PC_HOLD;
        end
      end
      HALT: begin
        if (accept_s) begin
          ir_valid_d = 1'b0;
        end else begin
          ir_valid_d = ir_valid_q;
        end
      end
      default: begin
        pc_sel_s = PC_HOLD;
      end
    endcase
  end

  assign im_addr  = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule
